// File: rtl/aes_gcm_block_issuer.sv
// -----------------------------------------------------------------------------
// aes_gcm_block_issuer
//
// Front-end feeder of the AES-GCM encrypt pipeline. A job is started with an
// IV and the number of full 128-bit AAD and plaintext blocks. The block then
// accepts the AAD blocks followed by the plaintext blocks on a valid/ready
// stream. It emits exactly one registered pipeline slot per cycle:
//   INIT  : job header (J0, instance size)
//   AAD   : one AAD block
//   PT    : one plaintext block with its counter block
//   LEN   : GCM length block {aad_bits, pt_bits}, coincident with o_done
//   BUBBLE: nothing useful (idle, or no input block this cycle)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           job start pulse, honoured only in IDLE
//   i_iv              96-bit IV, sampled with i_start
//   i_aad_nblk        AAD block count, sampled with i_start
//   i_pt_nblk         plaintext block count, sampled with i_start
//   i_data_valid      input block valid
//   i_data            AAD or plaintext block, in job order
//   o_data_ready      block accepted when i_data_valid && o_data_ready
//   o_phase           0 BUBBLE, 1 INIT, 2 AAD, 3 PT, 4 LEN
//   o_plain_text      plaintext block in PT slots, else 0
//   o_aad             AAD block in AAD slots, length block in LEN slot, else 0
//   o_h               always 0 (the all-zero block is encrypted to form H)
//   o_encrypted_j0    J0 = IV || 32'h1, held for the whole job
//   o_encrypted_cb    counter block for the current PT slot, else 0
//   o_instance_size   {64-bit AAD bit length, 64-bit PT bit length}
//   o_busy            high from the cycle after i_start until o_done
//   o_done            one-cycle pulse with the LEN slot
// -----------------------------------------------------------------------------
module aes_gcm_block_issuer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [0:95]      i_iv,
    input  logic [CNT_W-1:0] i_aad_nblk,
    input  logic [CNT_W-1:0] i_pt_nblk,
    input  logic             i_data_valid,
    input  logic [0:127]     i_data,
    output logic             o_data_ready,
    output logic [0:2]       o_phase,
    output logic [0:127]     o_plain_text,
    output logic [0:127]     o_aad,
    output logic [0:127]     o_h,
    output logic [0:127]     o_encrypted_j0,
    output logic [0:127]     o_encrypted_cb,
    output logic [0:127]     o_instance_size,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_AAD  = 3'd2,
        S_PT   = 3'd3,
        S_LEN  = 3'd4
    } state_t;

    localparam logic [0:2] PH_BUBBLE = 3'd0;
    localparam logic [0:2] PH_INIT   = 3'd1;
    localparam logic [0:2] PH_AAD    = 3'd2;
    localparam logic [0:2] PH_PT     = 3'd3;
    localparam logic [0:2] PH_LEN    = 3'd4;

    // GCM inc32: only the rightmost 32 bits count, wrapping modulo 2^32.
    function automatic logic [0:127] inc32(input logic [0:127] blk);
        return {blk[0:95], blk[96:127] + 32'd1};
    endfunction

    state_t           state_r;
    logic [0:127]     cb_r;
    logic [CNT_W-1:0] aad_left_r;
    logic [CNT_W-1:0] pt_left_r;

    logic             hs_s;
    logic [63:0]      aad_bits_s;
    logic [63:0]      pt_bits_s;

    // Handshake and bit lengths of the job being offered on i_start.
    always_comb begin
        hs_s       = i_data_valid && o_data_ready;
        aad_bits_s = 64'(i_aad_nblk) << 7;
        pt_bits_s  = 64'(i_pt_nblk) << 7;
    end

    // Job FSM and registered slot outputs; every cycle produces one slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            cb_r            <= 128'h0;
            aad_left_r      <= '0;
            pt_left_r       <= '0;
            o_data_ready    <= 1'b0;
            o_phase         <= PH_BUBBLE;
            o_plain_text    <= 128'h0;
            o_aad           <= 128'h0;
            o_h             <= 128'h0;
            o_encrypted_j0  <= 128'h0;
            o_encrypted_cb  <= 128'h0;
            o_instance_size <= 128'h0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            // Slot defaults: a BUBBLE with empty data fields.
            o_phase        <= PH_BUBBLE;
            o_plain_text   <= 128'h0;
            o_aad          <= 128'h0;
            o_encrypted_cb <= 128'h0;
            o_h            <= 128'h0;
            o_done         <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    o_data_ready <= 1'b0;
                    if (i_start) begin
                        o_encrypted_j0  <= {i_iv, 32'h0000_0001};
                        o_instance_size <= {aad_bits_s, pt_bits_s};
                        aad_left_r      <= i_aad_nblk;
                        pt_left_r       <= i_pt_nblk;
                        o_busy          <= 1'b1;
                        state_r         <= S_INIT;
                    end else begin
                        o_encrypted_j0  <= 128'h0;
                        o_instance_size <= 128'h0;
                        o_busy          <= 1'b0;
                    end
                end

                S_INIT: begin
                    o_phase <= PH_INIT;
                    cb_r    <= inc32(o_encrypted_j0);
                    // Ready is registered, so it is set here for the next state.
                    if (aad_left_r != '0) begin
                        state_r      <= S_AAD;
                        o_data_ready <= 1'b1;
                    end else if (pt_left_r != '0) begin
                        state_r      <= S_PT;
                        o_data_ready <= 1'b1;
                    end else begin
                        state_r      <= S_LEN;
                        o_data_ready <= 1'b0;
                    end
                end

                S_AAD: begin
                    if (hs_s) begin
                        o_phase    <= PH_AAD;
                        o_aad      <= i_data;
                        aad_left_r <= aad_left_r - CNT_W'(1);
                        if (aad_left_r == CNT_W'(1)) begin
                            if (pt_left_r != '0) begin
                                state_r      <= S_PT;
                                o_data_ready <= 1'b1;
                            end else begin
                                state_r      <= S_LEN;
                                o_data_ready <= 1'b0;
                            end
                        end
                    end
                end

                S_PT: begin
                    if (hs_s) begin
                        o_phase        <= PH_PT;
                        o_plain_text   <= i_data;
                        o_encrypted_cb <= cb_r;
                        cb_r           <= inc32(cb_r);
                        pt_left_r      <= pt_left_r - CNT_W'(1);
                        if (pt_left_r == CNT_W'(1)) begin
                            state_r      <= S_LEN;
                            o_data_ready <= 1'b0;
                        end
                    end
                end

                S_LEN: begin
                    o_phase      <= PH_LEN;
                    o_aad        <= o_instance_size;
                    o_done       <= 1'b1;
                    o_busy       <= 1'b0;
                    o_data_ready <= 1'b0;
                    state_r      <= S_IDLE;
                end

                default: begin
                    state_r      <= S_IDLE;
                    o_data_ready <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
